// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default latencies, op classification.
package md_defs;

  localparam int unsigned MD_OP_W         = 3;
  localparam int unsigned MD_DATA_W       = 32;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_RSVD  = 3'b111
  } md_op_e;

  // Ops that occupy the unit for a multi-cycle latency window.
  function automatic logic is_long_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Purely combinational MD arithmetic: 64-bit {hi,lo} result and divide-by-zero flag.
// Ports: op_i (md op), a_i/b_i (operands) -> phi_o/plo_o (pending HI/LO), div0_o.
module md_calc
  import md_defs::*;
(
  input  logic [MD_OP_W-1:0]   op_i,
  input  logic [MD_DATA_W-1:0] a_i,
  input  logic [MD_DATA_W-1:0] b_i,
  output logic [MD_DATA_W-1:0] phi_o,
  output logic [MD_DATA_W-1:0] plo_o,
  output logic                 div0_o
);

  logic signed [2*MD_DATA_W-1:0] sa, sb, prod_s;
  logic        [2*MD_DATA_W-1:0] prod_u;
  logic                          sdiv, neg_q, neg_r;
  logic        [MD_DATA_W-1:0]   ua, ub, ub_safe, uq, ur, q, r;

  // Multipliers: sign- or zero-extend to 64 bits and keep the low 64 bits of the product.
  assign sa     = {{MD_DATA_W{a_i[MD_DATA_W-1]}}, a_i};
  assign sb     = {{MD_DATA_W{b_i[MD_DATA_W-1]}}, b_i};
  assign prod_s = sa * sb;
  assign prod_u = {{MD_DATA_W{1'b0}}, a_i} * {{MD_DATA_W{1'b0}}, b_i};

  // One shared unsigned divider; signed divide works on magnitudes and fixes signs afterwards,
  // which also yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
  assign sdiv    = (op_i == MD_DIV);
  assign ua      = (sdiv && a_i[MD_DATA_W-1]) ? (-a_i) : a_i;
  assign ub      = (sdiv && b_i[MD_DATA_W-1]) ? (-b_i) : b_i;
  assign ub_safe = (ub == '0) ? MD_DATA_W'(1) : ub;
  assign uq      = ua / ub_safe;
  assign ur      = ua % ub_safe;
  assign neg_q   = sdiv && (a_i[MD_DATA_W-1] ^ b_i[MD_DATA_W-1]);
  assign neg_r   = sdiv && a_i[MD_DATA_W-1];
  assign q       = neg_q ? (-uq) : uq;
  assign r       = neg_r ? (-ur) : ur;

  // Result select.
  always_comb begin
    phi_o  = '0;
    plo_o  = '0;
    div0_o = 1'b0;
    case (op_i)
      MD_MULT:  {phi_o, plo_o} = prod_s;
      MD_MULTU: {phi_o, plo_o} = prod_u;
      MD_DIV, MD_DIVU: begin
        phi_o  = r;
        plo_o  = q;
        div0_o = (b_i == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide responder owning HI/LO. Results are computed at accept and
// committed after a fixed latency; MTHI/MTLO write in one cycle.
// Ports: clk, reset (async high), start/md_op/a/b (issue), busy/hold (status), hi/lo (architectural).
module md_unit
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MD_OP_W-1:0]   md_op,
  input  logic [MD_DATA_W-1:0] a,
  input  logic [MD_DATA_W-1:0] b,
  output logic                 busy,
  output logic                 hold,
  output logic [MD_DATA_W-1:0] hi,
  output logic [MD_DATA_W-1:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MD_DATA_W-1:0]   phi_q, phi_d, plo_q, plo_d;
  logic                   upd_q, upd_d;
  logic [MD_DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [MD_DATA_W-1:0]   calc_hi, calc_lo;
  logic                   calc_div0;

  md_calc u_calc (
    .op_i   (md_op),
    .a_i    (a),
    .b_i    (b),
    .phi_o  (calc_hi),
    .plo_o  (calc_lo),
    .div0_o (calc_div0)
  );

  // State and architectural registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      upd_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      upd_q   <= upd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Accept / count / commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    upd_d   = upd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_long_op(md_op)) begin
            phi_d   = calc_hi;
            plo_d   = calc_lo;
            upd_d   = !calc_div0;   // divide by zero burns the latency but leaves HI/LO alone
            cnt_d   = is_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_d = ST_RUN;
          end else if (md_op == MD_MTHI) begin
            hi_d = a;
          end else if (md_op == MD_MTLO) begin
            lo_d = a;
          end
        end
      end
      ST_RUN: begin
        // start is ignored while running.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (upd_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign hold = busy | (start & is_long_op(md_op));
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy, hold;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] OP_MULT = 3'b001, OP_MULTU = 3'b010, OP_DIV = 3'b011,
                         OP_DIVU = 3'b100, OP_MTHI = 3'b101, OP_MTLO = 3'b110;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
    .busy(busy), .hold(hold), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Drive one start for a single edge; returns hold as seen just before that edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                       output logic hold_seen);
    start = 1'b1; md_op = op; a = av; b = bv;
    #1 hold_seen = hold;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'b000; a = '0; b = '0;
  endtask

  // Count consecutive busy cycles starting at the current sample point (bounded).
  task automatic run_busy(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (hold !== 1'b0) begin failures++; $display("FAIL reset_hold got=%b exp=0", hold); end
    checks++; if (hi !== 32'h0)  begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0)  begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
  endtask

  task automatic test_reset_mid_op();
    logic h;
    issue(OP_MTHI, 32'h55, 32'h0, h);
    issue(OP_MTLO, 32'h66, 32'h0, h);
    checks++; if (hi !== 32'h55 || lo !== 32'h66) begin failures++; $display("FAIL pre_reset_mt got=%h/%h exp=55/66", hi, lo); end
    issue(OP_MULT, 32'd3, 32'd4, h);
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_mult_busy got=%b exp=1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
      begin failures++; $display("FAIL async_reset got busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo); end
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
      begin failures++; $display("FAIL no_commit_after_reset got busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo); end
  endtask

  task automatic test_mult();
    logic h; int n;
    issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, h);
    checks++; if (h !== 1'b1) begin failures++; $display("FAIL mult_hold_at_start got=%b exp=1", h); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL mult_hilo_held got=%h/%h exp=0/0", hi, lo); end
    run_busy(n);
    checks++; if (n != 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE)
      begin failures++; $display("FAIL mult_result got=%h/%h exp=ffffffff/fffffffe", hi, lo); end
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, h);
    run_busy(n);
    checks++; if (n != 5) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=5", n); end
    checks++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE)
      begin failures++; $display("FAIL multu_result got=%h/%h exp=00000001/fffffffe", hi, lo); end
  endtask

  task automatic test_div();
    logic h; int n;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, h);
    run_busy(n);
    checks++; if (n != 10) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=10", n); end
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF)
      begin failures++; $display("FAIL div_result got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", hi, lo); end
    issue(OP_DIVU, 32'd7, 32'd2, h);
    run_busy(n);
    checks++; if (n != 10) begin failures++; $display("FAIL divu_busy_cycles got=%0d exp=10", n); end
    checks++; if (lo !== 32'd3 || hi !== 32'd1)
      begin failures++; $display("FAIL divu_result got hi=%h lo=%h exp hi=1 lo=3", hi, lo); end
  endtask

  task automatic test_mthi_div0();
    logic h; int n;
    issue(OP_MTHI, 32'h1234, 32'h0, h);
    checks++; if (hi !== 32'h1234 || busy !== 1'b0 || h !== 1'b0)
      begin failures++; $display("FAIL mthi got hi=%h busy=%b hold=%b exp 1234/0/0", hi, busy, h); end
    issue(OP_DIV, 32'd99, 32'd0, h);
    run_busy(n);
    checks++; if (n != 10) begin failures++; $display("FAIL div0_busy_cycles got=%0d exp=10", n); end
    checks++; if (hi !== 32'h1234 || lo !== 32'd3)
      begin failures++; $display("FAIL div0_unchanged got hi=%h lo=%h exp hi=1234 lo=3", hi, lo); end
    issue(3'b000, 32'hDEAD, 32'hBEEF, h);
    issue(3'b111, 32'hDEAD, 32'hBEEF, h);
    checks++; if (hi !== 32'h1234 || lo !== 32'd3 || busy !== 1'b0)
      begin failures++; $display("FAIL none_noeffect got hi=%h lo=%h busy=%b", hi, lo, busy); end
  endtask

  task automatic test_start_while_busy();
    logic h; int n; int hold_lo;
    hold_lo = 0;
    issue(OP_DIV, 32'd100, 32'd7, h);
    repeat (3) begin
      if (hold !== 1'b1) hold_lo++;
      @(posedge clk); #1;
    end
    issue(OP_MULTU, 32'd5, 32'd6, h);
    if (h !== 1'b1) hold_lo++;
    n = 4;
    while (busy === 1'b1 && n < 100) begin
      if (hold !== 1'b1) hold_lo++;
      n++;
      @(posedge clk); #1;
    end
    checks++; if (hold_lo != 0) begin failures++; $display("FAIL busy_hold_low got=%0d exp=0", hold_lo); end
    checks++; if (n != 10) begin failures++; $display("FAIL ignored_start_busy_cycles got=%0d exp=10", n); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2)
      begin failures++; $display("FAIL ignored_start_result got hi=%h lo=%h exp hi=2 lo=e", hi, lo); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || lo !== 32'd14 || hi !== 32'd2)
      begin failures++; $display("FAIL ignored_start_late got busy=%b hi=%h lo=%h", busy, hi, lo); end
  endtask

  task automatic test_back_to_back();
    logic h; int n;
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, h);
    run_busy(n);
    checks++; if (n != 10) begin failures++; $display("FAIL ovf_busy_cycles got=%0d exp=10", n); end
    checks++; if (lo !== 32'h8000_0000 || hi !== 32'h0)
      begin failures++; $display("FAIL ovf_result got hi=%h lo=%h exp hi=0 lo=80000000", hi, lo); end
    issue(OP_MULT, 32'd3, 32'd4, h);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got busy=%b exp=1", busy); end
    run_busy(n);
    checks++; if (n != 5) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=5", n); end
    checks++; if (hi !== 32'h0 || lo !== 32'd12)
      begin failures++; $display("FAIL b2b_result got hi=%h lo=%h exp hi=0 lo=c", hi, lo); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'b000; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_reset_mid_op();
    test_mult();
    test_div();
    test_mthi_div0();
    test_start_while_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
